rr_mux_arbiter_4: RTL
=====================

Name: rr_mux_arbiter_4

Overview:
- Shares one W-bit output channel between 4 requesters.
- Sequences the 4:1 mux select with a round-robin arbiter; valid/ready handshake on every input and on the output.
- Output is registered, so there is one pipeline stage from the input handshake to the output.
- Sits in front of any single-consumer resource fed by several producers.

Parameters:
- W, 4, data width of each requester and of the output.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- in_valid  input  4  per-requester valid; bit i belongs to requester i
- in_data  input  4*W  packed; requester i occupies [i*W +: W]
- in_last  input  4  per-requester end-of-packet flag; used only with the optional feature
- in_ready  output  4  per-requester ready; at most one bit set
- out_valid  output  1  output register holds a word
- out_data  output  W  registered selected word
- out_sel  output  2  index of the requester that produced out_data
- out_ready  input  1  consumer accepts the word

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - lock=0.
  - Any transfer in the same cycle is discarded.
- Slot free: free = ~out_valid | out_ready.
- Grant (combinational):
  - Select the first i with in_valid[i]=1, searching i = ptr, ptr+1, ... mod 4.
  - No valid bit set means no grant.
- in_ready[i] = grant[i] & free, so it is one-hot or zero.
- Input transfer on requester i when in_valid[i] & in_ready[i]. On the next posedge:
  - out_data <= in_data[i]
  - out_sel <= i
  - out_valid <= 1
  - ptr <= (i+1) mod 4, with 2-bit wrap-around, so 3 goes to 0.
- Output transfer when out_valid & out_ready.
  - Output transfer without an input transfer sets out_valid <= 0.
  - Simultaneous input and output transfer: the register is reloaded and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Stall: out_valid=1 & out_ready=0.
  - in_ready=0, and out_data/out_sel hold.
  - ptr holds, and in_valid changes do not affect the stored word.
- Input rule: requesters keep in_valid and in_data stable until accepted. The arbiter may pick a different requester next cycle only if the grant changes because valid bits changed.
- Latency: an input accepted in cycle N is visible on out_* in cycle N+1.
- Fairness: with all 4 requesting continuously and out_ready=1, the grant order is 0,1,2,3,0,...
- No grant when in_valid=0: ptr holds and out_valid drains normally.

Optional Feature:
- Macro: RR_MUX_ARBITER_LOCK_EN
- Defined, packet lock:
  - After a transfer from i with in_last[i]=0: lock <= 1 and the locked index is i.
  - While locked, grant = i only. Other valid requesters wait even if i drops in_valid.
  - ptr does not advance.
  - A transfer from i with in_last[i]=1 clears lock and sets ptr <= (i+1) mod 4.
  - rst clears lock.
- Not defined:
  - in_last is ignored and the lock state is not built.
  - Every transfer re-arbitrates, and every transfer advances ptr.

Decomposition:
- Package rr_mux_arbiter_pkg:
  - N_REQ = 4
  - SEL_W = 2
  - typedef logic [SEL_W-1:0] req_idx_t
- Sub-module rr_pick_4 (combinational):
  - Inputs: req[3:0], ptr.
  - Outputs: one-hot grant and the granted index.
  - Instantiated once.
  - Datapath select uses the existing 4:1 mux style, replicated across W.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=4'hF, then check out_valid=0, out_data=0, in_ready=0 during reset. After release with in_valid=4'hF, the first in_ready=4'b0001.
- Round-robin: W=4, in_data={d,c,b,a}, in_valid=4'hF, out_ready=1 for 8 cycles. Expect out_data a,b,c,d,a,b,c,d, out_sel 0,1,2,3,0,..., and out_valid=1 continuously from the second cycle.
- Backpressure: a single accepted word 'h5, then out_ready=0 for 3 cycles. out_data holds 'h5, in_ready=0, ptr unchanged. Releasing out_ready gives the next grant to the next requester in order.
- Sparse/wrap: only requesters 3 and 1 valid, ptr=0. Expect grant 1, then 3, then 1 (wrap 3 to 0 to 1).
- Drain: single word 'h9 from requester 2, in_valid then 0, out_ready=1. Expect out_valid high for exactly 1 cycle.
- Lock (macro defined): requester 0 sends 3 words with in_last=0,0,1 while requester 1 is valid throughout. Expect out_sel 0,0,0, then 1. Without the macro, expect 0,1,0,1.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and index type for the 4-requester round-robin mux arbiter.
package rr_mux_arbiter_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    typedef logic [SEL_W-1:0] req_idx_t;
endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod 4.
module rr_pick_4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         ptr,
    output logic [N_REQ-1:0] gnt,
    output req_idx_t         idx,
    output logic             any
);
    req_idx_t cand;

    always_comb begin
        gnt  = '0;
        idx  = ptr;
        any  = 1'b0;
        cand = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + req_idx_t'(k);
            if (!any && req[cand]) begin
                any      = 1'b1;
                idx      = cand;
                gnt[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_mux_arbiter_4.sv
// 4:1 round-robin arbitrated mux with a registered valid/ready output stage.
// Optional packet lock (in_last driven) is built when RR_MUX_ARBITER_LOCK_EN is defined.
module rr_mux_arbiter_4
    import rr_mux_arbiter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   in_valid,
    input  logic [N_REQ*W-1:0] in_data,
    input  logic [N_REQ-1:0]   in_last,
    output logic [N_REQ-1:0]   in_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);
    req_idx_t         ptr;
    logic [N_REQ-1:0] req_eff;
    logic [N_REQ-1:0] gnt;
    req_idx_t         idx;
    logic             any;
    logic             free;
    logic             xfer_in;
    logic [W-1:0]     mux_data;

`ifdef RR_MUX_ARBITER_LOCK_EN
    logic     lock;
    req_idx_t lock_idx;

    // While locked only the owner may be granted, even if it drops valid.
    always_comb begin
        req_eff = in_valid;
        if (lock)
            req_eff = in_valid & (N_REQ'(1) << lock_idx);
    end
`else
    logic unused_last;
    assign unused_last = ^in_last;
    assign req_eff     = in_valid;
`endif

    rr_pick_4 u_pick (
        .req (req_eff),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    assign free     = ~out_valid | out_ready;
    assign in_ready = gnt & {N_REQ{free & ~rst}};
    assign xfer_in  = any & free;

    for (genvar b = 0; b < W; b++) begin : g_bit
        always_comb begin
            case (idx)
                2'd0:    mux_data[b] = in_data[b];
                2'd1:    mux_data[b] = in_data[W+b];
                2'd2:    mux_data[b] = in_data[2*W+b];
                default: mux_data[b] = in_data[3*W+b];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
`ifdef RR_MUX_ARBITER_LOCK_EN
            lock      <= 1'b0;
            lock_idx  <= '0;
`endif
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_sel   <= idx;
`ifdef RR_MUX_ARBITER_LOCK_EN
            if (in_last[idx]) begin
                lock <= 1'b0;
                ptr  <= idx + 2'd1;
            end else begin
                lock     <= 1'b1;
                lock_idx <= idx;
            end
`else
            ptr <= idx + 2'd1;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
